// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the shared ALU adder.
// Shift-add multiply and restoring divide, one add/sub per cycle, WIDTH iterations.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_kill,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_alu_own,
  output logic [WIDTH-1:0] o_alu_op_a,
  output logic [WIDTH-1:0] o_alu_op_b,
  output logic             o_alu_sub,
  output logic [3:0]       o_alu_op_sel,
  output logic [1:0]       o_alu_bool_op,
  output logic             o_alu_shift_dir,
  input  logic [WIDTH-1:0] i_alu_result
);

  // state  | meaning
  // S_IDLE | waiting for i_start
  // S_RUN  | one ALU add/sub per cycle, count 0..WIDTH-1
  // S_DONE | o_result valid, o_done high for this cycle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand for MUL ops, divisor for DIV ops
  logic [WIDTH-1:0] hi_q;     // product high / remainder
  logic [WIDTH-1:0] lo_q;     // product low (multiplier) / quotient (dividend)
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;

  logic             is_div;
  logic             last;
  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] sh_lo;
  logic             sh_top;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             carry;
  logic             borrow;
  logic             ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    is_div   = op_q[1];
    last     = (cnt_q == CW'(WIDTH - 1));
    accept   = i_start & ~i_kill;
    div_zero = i_op[1] & (i_b == '0);
    sh_top   = hi_q[WIDTH-1];
    sh_lo    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    alu_a    = is_div ? sh_lo : hi_q;
    alu_b    = (is_div || lo_q[0]) ? opnd_q : '0;
    // The shared ALU gives no carry/borrow out, so recover them from the MSBs.
    carry    = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
               ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~i_alu_result[WIDTH-1]);
    borrow   = (~alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
               (~(alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) & i_alu_result[WIDTH-1]);
    ge       = sh_top | ~borrow;
    if (is_div) begin
      step_hi = ge ? i_alu_result : sh_lo;
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = {carry, i_alu_result[WIDTH-1:1]};
      step_lo = {i_alu_result[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = div_zero ? S_DONE : S_RUN;
      S_RUN: begin
        if (i_kill)    state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept) state_d = div_zero ? S_DONE : S_RUN;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_RUN && accept) begin
        op_q   <= i_op;
        opnd_q <= i_op[1] ? i_b : i_a;
        hi_q   <= div_zero ? i_a : '0;
        lo_q   <= div_zero ? '1 : (i_op[1] ? i_a : i_b);
        cnt_q  <= '0;
        if (div_zero) res_q <= i_op[0] ? i_a : '1;
      end else if (state_q == S_RUN && !i_kill) begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        cnt_q <= cnt_q + 1'b1;
        // op bit 0 picks the high word: MULHU -> hi, REMU -> rem
        if (last) res_q <= op_q[0] ? step_hi : step_lo;
      end
    end
  end

  always_comb begin
    o_busy          = (state_q == S_RUN);
    o_done          = (state_q == S_DONE);
    o_result        = res_q;
    o_alu_own       = o_busy;
    o_alu_op_a      = o_busy ? alu_a : '0;
    o_alu_op_b      = o_busy ? alu_b : '0;
    o_alu_sub       = o_busy & is_div;
    o_alu_op_sel    = {3'b000, o_busy};
    o_alu_bool_op   = 2'b01;
    o_alu_shift_dir = 1'b0;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; models the shared ALU adder/subtractor and
// checks results, latency and ALU ownership against hand-computed values.
`timescale 1ns/1ps
module tb_muldiv_seq;
  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [1:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_kill;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic         o_alu_own;
  logic [W-1:0] o_alu_op_a;
  logic [W-1:0] o_alu_op_b;
  logic         o_alu_sub;
  logic [3:0]   o_alu_op_sel;
  logic [1:0]   o_alu_bool_op;
  logic         o_alu_shift_dir;
  logic [W-1:0] i_alu_result;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_kill(i_kill),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_alu_own(o_alu_own), .o_alu_op_a(o_alu_op_a), .o_alu_op_b(o_alu_op_b),
    .o_alu_sub(o_alu_sub), .o_alu_op_sel(o_alu_op_sel),
    .o_alu_bool_op(o_alu_bool_op), .o_alu_shift_dir(o_alu_shift_dir),
    .i_alu_result(i_alu_result)
  );

  always #5 i_clk = ~i_clk;

  assign i_alu_result = o_alu_sub ? (o_alu_op_a - o_alu_op_b) : (o_alu_op_a + o_alu_op_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output int own);
    n = n0; own = 0;
    while (o_done !== 1'b1 && n < 200) begin
      if (o_alu_own === 1'b1) own++;
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int exp_lat, input int exp_own);
    int n, own;
    start_op(op, a, b);
    wait_done(1, n, own);
    chk({tag, "_done"}, 64'(o_done), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, 64'(o_result), 64'(exp));
    chk({tag, "_own"}, 64'(own), 64'(exp_own));
    @(negedge i_clk);
    chk({tag, "_hold"}, 64'(o_result), 64'(exp));
    chk({tag, "_pulse"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    int n, own, dcount;
    i_rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0; i_kill = 1'b0;
    #12;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_own", 64'(o_alu_own), 64'd0);
    chk("rst_op_sel", 64'(o_alu_op_sel), 64'd0);
    chk("rst_bool_op", 64'(o_alu_bool_op), 64'd1);
    chk("rst_shift", 64'(o_alu_shift_dir), 64'd0);
    chk("rst_op_a", 64'(o_alu_op_a), 64'd0);
    chk("rst_op_b", 64'(o_alu_op_b), 64'd0);
    chk("rst_sub", 64'(o_alu_sub), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33, 32);
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 32);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33, 32);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 32);
    run_op("divu_sh", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, 32);
    run_op("remu_sh", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 32);
    run_op("divu_z", 2'b10, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_z", 2'b11, 32'd1234, 32'd0, 32'd1234, 1, 0);

    // ALU control while dividing
    start_op(2'b10, 32'd50, 32'd5);
    chk("div_run_own", 64'(o_alu_own), 64'd1);
    chk("div_run_sub", 64'(o_alu_sub), 64'd1);
    chk("div_run_sel", 64'(o_alu_op_sel), 64'd1);
    chk("div_run_b", 64'(o_alu_op_b), 64'd5);
    wait_done(1, n, own);
    chk("div_50_5", 64'(o_result), 64'd10);
    @(negedge i_clk);

    // Kill in RUN cycle 10
    start_op(2'b00, 32'd1000, 32'd1000);
    chk("mul_run_sub", 64'(o_alu_sub), 64'd0);
    repeat (9) @(negedge i_clk);
    chk("kill_pre_busy", 64'(o_busy), 64'd1);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    chk("kill_busy", 64'(o_busy), 64'd0);
    chk("kill_own", 64'(o_alu_own), 64'd0);
    dcount = 0;
    repeat (40) begin
      if (o_done === 1'b1) dcount++;
      @(negedge i_clk);
    end
    chk("kill_no_done", 64'(dcount), 64'd0);
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15, 33, 32);

    // Ignored start pulse during RUN, then back-to-back start in DONE
    start_op(2'b00, 32'd9, 32'd11);
    repeat (4) @(negedge i_clk);
    i_op = 2'b11; i_a = 32'd5; i_b = 32'd3; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(6, n, own);
    chk("b2b1_lat", 64'(n), 64'd33);
    chk("b2b1_res", 64'(o_result), 64'd99);
    start_op(2'b10, 32'd1000, 32'd10);
    wait_done(1, n, own);
    chk("b2b2_lat", 64'(n), 64'd33);
    chk("b2b2_res", 64'(o_result), 64'd100);
    @(negedge i_clk);

    // Asynchronous reset mid-RUN
    start_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) @(negedge i_clk);
    chk("pre_rst_own", 64'(o_alu_own), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_done", 64'(o_done), 64'd0);
    chk("mid_rst_own", 64'(o_alu_own), 64'd0);
    chk("mid_rst_sel", 64'(o_alu_op_sel), 64'd0);
    chk("mid_rst_result", 64'(o_result), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_op("post_rst", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 33, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
